// File: rtl/mac_axi_pkg.sv
// Shared constants, channel indices and the reference MAC function for the MAC stream driver.
// The reference function is used by the driver only when MAC_DRV_CHECK_EN is defined.
package mac_axi_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Field positions inside the packed operand word, in units of DATA_WIDTH.
    localparam int OFS_A = 0;
    localparam int OFS_B = 1;
    localparam int OFS_C = 2;
    localparam int OFS_D = 3;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } channel_t;

    // Operands arrive already sign-extended; the result is masked to dw bits (dw < 32).
    function automatic int mac_expected(input int a, input int b, input int c, input int d,
                                        input int dw);
        int prod;
        prod = (a + b) * (c + d);
        return prod & ((1 << dw) - 1);
    endfunction

endpackage

// File: rtl/mac_drv_exp_fifo.sv
// In-order FIFO of expected MAC results with full/empty flags.
// Instantiated by mac_axi_driver only when MAC_DRV_CHECK_EN is defined.
module mac_drv_exp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_en    = push & ~full;
    assign rd_en    = pop & ~empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_axi_driver.sv
// Forks packed operand words onto four valid/ready channels under a credit limit and
// forwards the result stream through a one-entry register. Result checking: MAC_DRV_CHECK_EN.
module mac_axi_driver
    import mac_axi_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_valid,
    input  logic                    a_ready,
    output logic [DATA_WIDTH-1:0]   b_data,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [DATA_WIDTH-1:0]   c_data,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    input  logic [DATA_WIDTH-1:0]   r_data,
    input  logic                    r_valid,
    output logic                    r_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [CNT_WIDTH-1:0]    issued_count,
    output logic [CNT_WIDTH-1:0]    returned_count,
    output logic                    busy,
    output logic                    mismatch,
    output logic [7:0]              err_count
);

    localparam int OUT_W = 4;

    logic [4*DATA_WIDTH-1:0] op_data;
    logic                    op_full;
    logic [3:0]              sent;
    logic [OUT_W-1:0]        outstanding;
    logic [3:0]              ch_ready;
    logic [3:0]              ch_valid;
    logic [3:0]              ch_hs;
    logic                    dispatch_done;
    logic                    r_accept;

    assign ch_ready      = {d_ready, c_ready, b_ready, a_ready};
    assign ch_valid      = {4{op_full}} & ~sent;
    assign ch_hs         = ch_valid & ch_ready;
    assign dispatch_done = op_full & (&(sent | ch_hs));
    assign s_ready       = ~op_full & (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign r_ready       = ~o_valid | o_ready;
    assign r_accept      = r_valid & r_ready;
    assign busy          = op_full | (outstanding != '0);

    assign a_valid = ch_valid[CH_A];
    assign b_valid = ch_valid[CH_B];
    assign c_valid = ch_valid[CH_C];
    assign d_valid = ch_valid[CH_D];
    assign a_data  = op_data[OFS_A*DATA_WIDTH +: DATA_WIDTH];
    assign b_data  = op_data[OFS_B*DATA_WIDTH +: DATA_WIDTH];
    assign c_data  = op_data[OFS_C*DATA_WIDTH +: DATA_WIDTH];
    assign d_data  = op_data[OFS_D*DATA_WIDTH +: DATA_WIDTH];

    // The capture branch only fires while op_full is low, so channel data stays stable while valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_full <= 1'b0;
            sent    <= '0;
            op_data <= '0;
        end else if (s_valid && s_ready) begin
            op_data <= s_data;
            op_full <= 1'b1;
            sent    <= '0;
        end else if (dispatch_done) begin
            op_full <= 1'b0;
            sent    <= '0;
        end else begin
            sent <= sent | ch_hs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding  <= '0;
            issued_count <= '0;
        end else begin
            if (dispatch_done) begin
                issued_count <= issued_count + CNT_WIDTH'(1);
            end
            case ({dispatch_done, r_accept})
                2'b10: outstanding <= outstanding + OUT_W'(1);
                2'b01: begin
                    if (outstanding != '0) begin
                        outstanding <= outstanding - OUT_W'(1);
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid        <= 1'b0;
            o_data         <= '0;
            returned_count <= '0;
        end else if (r_accept) begin
            o_data         <= r_data;
            o_valid        <= 1'b1;
            returned_count <= returned_count + CNT_WIDTH'(1);
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef MAC_DRV_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_push_data;
    logic [DATA_WIDTH-1:0] exp_head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  check_fail;
    logic                  mismatch_q;
    logic [7:0]            err_q;

    assign exp_push_data = DATA_WIDTH'(mac_expected(
        int'($signed(a_data)), int'($signed(b_data)),
        int'($signed(c_data)), int'($signed(d_data)), DATA_WIDTH));

    // A result arriving in the same cycle its set dispatches into an empty FIFO bypasses it.
    assign fifo_push  = dispatch_done & ~fifo_full & ~(r_accept & fifo_empty);
    assign fifo_pop   = r_accept & ~fifo_empty;
    assign check_fail = r_accept & (fifo_empty ? (~dispatch_done | (exp_push_data != r_data))
                                               : (exp_head != r_data));

    mac_drv_exp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_exp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (exp_push_data),
        .pop       (fifo_pop),
        .pop_data  (exp_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else if (check_fail) begin
            mismatch_q <= 1'b1;
            if (err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = err_q;
`else
    assign mismatch  = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_mac_axi_driver.sv
// Directed scoreboard bench for mac_axi_driver; expected mismatch behaviour follows
// whether MAC_DRV_CHECK_EN is defined for the build.
module tb_mac_axi_driver;

    localparam int DW   = 8;
    localparam int MAXO = 4;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*DW-1:0] s_data;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   a_data, b_data, c_data, d_data;
    logic            a_valid, b_valid, c_valid, d_valid;
    logic            a_ready, b_ready, c_ready, d_ready;
    logic [DW-1:0]   r_data;
    logic            r_valid;
    logic            r_ready;
    logic [DW-1:0]   o_data;
    logic            o_valid;
    logic            o_ready;
    logic [CW-1:0]   issued_count;
    logic [CW-1:0]   returned_count;
    logic            busy;
    logic            mismatch;
    logic [7:0]      err_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_ch [4][$];
    logic [DW-1:0] exp_o [$];
    int            hs_cnt [4];
    int            hs_base [4];
    logic [3:0]    mon_valid;
    logic [3:0]    mon_ready;
    logic [DW-1:0] mon_data [4];

    mac_axi_driver #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .a_data         (a_data),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .b_data         (b_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .c_data         (c_data),
        .c_valid        (c_valid),
        .c_ready        (c_ready),
        .d_data         (d_data),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .r_data         (r_data),
        .r_valid        (r_valid),
        .r_ready        (r_ready),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .issued_count   (issued_count),
        .returned_count (returned_count),
        .busy           (busy),
        .mismatch       (mismatch),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    assign mon_valid   = {d_valid, c_valid, b_valid, a_valid};
    assign mon_ready   = {d_ready, c_ready, b_ready, a_ready};
    assign mon_data[0] = a_data;
    assign mon_data[1] = b_data;
    assign mon_data[2] = c_data;
    assign mon_data[3] = d_data;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout/unexpected required=event", name);
    endtask

    // Monitor: every completed handshake pops the matching expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (mon_valid[i] && mon_ready[i]) begin
                    hs_cnt[i]++;
                    if (exp_ch[i].size() == 0) report_fail($sformatf("ch%0d_unexpected", i));
                    else check_output($sformatf("ch%0d_data", i), 32'(mon_data[i]), 32'(exp_ch[i].pop_front()));
                end
            end
            if (o_valid && o_ready) begin
                if (exp_o.size() == 0) report_fail("o_unexpected");
                else check_output("o_data", 32'(o_data), 32'(exp_o.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap_hs();
        for (int i = 0; i < 4; i++) hs_base[i] = hs_cnt[i];
    endtask

    task automatic check_hs_once(input string tag);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("%s_hs_ch%0d", tag, i), 32'(hs_cnt[i] - hs_base[i]), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [4*DW-1:0] word);
        bit ok = 1'b0;
        s_data  = word;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) exp_ch[i].push_back(word[i*DW +: DW]);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
        end
        if (!ok) report_fail("s_accept_timeout");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic return_result(input logic [DW-1:0] data);
        bit ok = 1'b0;
        r_data  = data;
        r_valid = 1'b1;
        exp_o.push_back(data);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (r_ready) ok = 1'b1;
        end
        if (!ok) report_fail("r_accept_timeout");
        @(posedge clk);
        #1;
        r_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        r_data  = '0;
        r_valid = 1'b0;
        {a_ready, b_ready, c_ready, d_ready} = 4'hF;
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) hs_cnt[i] = 0;
        repeat (3) tick();
        reset = 1'b0;

        check_output("rst_s_ready", 32'(s_ready), 32'd1);
        check_output("rst_valids", 32'(mon_valid), 32'd0);
        check_output("rst_o_valid", 32'(o_valid), 32'd0);
        check_output("rst_issued", 32'(issued_count), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_err", 32'({mismatch, err_count}), 32'd0);

        // Single beat, everything ready, loopback result 21 = (1+2)*(3+4).
        snap_hs();
        apply_stimulus(32'h04030201);
        tick();
        check_hs_once("t1");
        check_output("t1_issued", 32'(issued_count), 32'd1);
        check_output("t1_valids_drop", 32'(mon_valid), 32'd0);
        check_output("t1_busy_outst", 32'(busy), 32'd1);
        return_result(8'd21);
        check_output("t1_o_valid", 32'(o_valid), 32'd1);
        check_output("t1_o_data", 32'(o_data), 32'd21);
        check_output("t1_returned", 32'(returned_count), 32'd1);
        check_output("t1_busy_idle", 32'(busy), 32'd0);

        // Channel B stalls for three cycles; the others complete once.
        b_ready = 1'b0;
        snap_hs();
        apply_stimulus(32'h04030201);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t2_acd_valid", 32'({d_valid, c_valid, a_valid}), 32'd0);
            check_output("t2_b_valid", 32'(b_valid), 32'd1);
            check_output("t2_b_data", 32'(b_data), 32'd2);
            check_output("t2_s_ready", 32'(s_ready), 32'd0);
        end
        b_ready = 1'b1;
        tick();
        check_hs_once("t2");
        check_output("t2_issued", 32'(issued_count), 32'd2);
        check_output("t2_b_drop", 32'(b_valid), 32'd0);
        return_result(8'h15);

        // Credit limit: four sets go out, the fifth waits for a returned result.
        for (int i = 0; i < 4; i++) apply_stimulus(32'h10203040 + 32'(i));
        tick();
        check_output("t3_issued4", 32'(issued_count), 32'd6);
        check_output("t3_s_ready_full", 32'(s_ready), 32'd0);
        s_data  = 32'h55667788;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t3_blocked5", 32'(s_ready), 32'd0);
            check_output("t3_hold_issued", 32'(issued_count), 32'd6);
        end
        s_valid = 1'b0;
        return_result(8'h31);
        check_output("t3_credit_back", 32'(s_ready), 32'd1);
        apply_stimulus(32'h55667788);
        tick();
        check_output("t3_issued5", 32'(issued_count), 32'd7);
        s_data  = 32'h99AABBCC;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t3_blocked6", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        check_output("t3_only_one_more", 32'(issued_count), 32'd7);
        for (int i = 0; i < 4; i++) return_result(8'h32 + 8'(i));
        check_output("t3_returned", 32'(returned_count), 32'd7);
        tick();
        check_output("t3_busy_idle", 32'(busy), 32'd0);

        // Output back-pressure: first result held, second waits, both delivered in order.
        apply_stimulus(32'h01010101);
        apply_stimulus(32'h02020202);
        tick();
        o_ready = 1'b0;
        return_result(8'h5A);
        check_output("t4_o_valid", 32'(o_valid), 32'd1);
        check_output("t4_o_hold", 32'(o_data), 32'h5A);
        check_output("t4_r_ready_low", 32'(r_ready), 32'd0);
        r_data  = 8'hA5;
        r_valid = 1'b1;
        exp_o.push_back(8'hA5);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("t4_r_stall", 32'(r_ready), 32'd0);
            check_output("t4_o_stable", 32'(o_data), 32'h5A);
        end
        o_ready = 1'b1;
        @(negedge clk);
        check_output("t4_r_ready_back", 32'(r_ready), 32'd1);
        tick();
        r_valid = 1'b0;
        check_output("t4_second", 32'(o_data), 32'hA5);
        check_output("t4_returned", 32'(returned_count), 32'd9);
        tick();
        check_output("t4_o_drained", 32'(o_valid), 32'd0);
        check_output("t4_busy_idle", 32'(busy), 32'd0);

        // Reset with A and C sent, B and D pending.
        b_ready = 1'b0;
        d_ready = 1'b0;
        apply_stimulus(32'h44332211);
        tick();
        check_output("t5_partial", 32'(mon_valid), 32'b1010);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) exp_ch[i].delete();
        tick();
        check_output("t5_valids", 32'(mon_valid), 32'd0);
        check_output("t5_s_ready", 32'(s_ready), 32'd1);
        check_output("t5_counts", 32'({issued_count, returned_count}), 32'd0);
        check_output("t5_busy", 32'(busy), 32'd0);
        reset   = 1'b0;
        b_ready = 1'b1;
        d_ready = 1'b1;
        tick();

        // Result check: (127+1)*(1+0) truncates to 0x80.
        apply_stimulus(32'h0001017F);
        tick();
        return_result(8'h80);
        check_output("t6_good_mismatch", 32'(mismatch), 32'd0);
        check_output("t6_good_err", 32'(err_count), 32'd0);
        apply_stimulus(32'h0001017F);
        tick();
        return_result(8'h00);
`ifdef MAC_DRV_CHECK_EN
        check_output("t6_bad_mismatch", 32'(mismatch), 32'd1);
        check_output("t6_bad_err", 32'(err_count), 32'd1);
`else
        check_output("t6_bad_mismatch", 32'(mismatch), 32'd0);
        check_output("t6_bad_err", 32'(err_count), 32'd0);
`endif
        check_output("t6_issued", 32'(issued_count), 32'd2);
        check_output("t6_returned", 32'(returned_count), 32'd2);

        repeat (3) tick();
        check_output("end_o_queue", 32'(exp_o.size()), 32'd0);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("end_ch%0d_queue", i), 32'(exp_ch[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
